dec138_bus32_mux32: RTL and testbench

Selection-primitive bundle for the instruction-decode stage. It packages three 74-series-style primitives behind one optional output register:
- a 3-to-8 decoder with active-low outputs (74x138 behaviour);
- an N-source 32-bit bus selector with active-low enables;
- a 32-bit 2:1 multiplexer.

Decode logic uses these to generate load/store/CSR one-hot strobes, immediate selection and ALU operand selection.

---
 rtl/dec138_bus32_mux32.sv | 112 +++++++++++
 tb/tb_dec138_bus32_mux32.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/dec138_bus32_mux32.sv
`default_nettype none
// ============================================================================
// Module  : dec138_bus32_mux32
// Brief   : 74x138-style 3:8 decoder, N-source 32-bit bus selector and
//           32-bit 2:1 mux, with an optional shared output register.
// Revision: 1.0 - initial release
// ============================================================================
module dec138_bus32_mux32 #(
    parameter int N       = 3,
    parameter bit REG_OUT = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2:0]      dec_a,
    input  logic            dec_g1,
    input  logic            dec_g2a_n,
    input  logic            dec_g2b_n,
    output logic [7:0]      dec_y_n,
    input  logic [N-1:0]    bus_en_n,
    input  logic [32*N-1:0] bus_d,
    output logic [31:0]     bus_y,
    output logic            bus_valid,
    output logic            bus_conflict,
    input  logic [31:0]     mux_a,
    input  logic [31:0]     mux_b,
    input  logic            mux_s,
    output logic [31:0]     mux_y
);

    localparam logic [N-1:0] c_one = N'(1);

    generate
        if (N < 1 || N > 8) begin : g_bad_n
            $error("dec138_bus32_mux32: N must be in 1..8");
        end
    endgenerate

    logic            w_dec_en;
    logic [7:0]      w_dec_y_n;
    logic [N-1:0]    w_bus_en;
    logic [31:0]     w_bus_y;
    logic            w_bus_valid;
    logic            w_bus_conflict;
    logic [31:0]     w_mux_y;

    assign w_dec_en = dec_g1 & ~dec_g2a_n & ~dec_g2b_n;

    always_comb begin
        w_dec_y_n = 8'hFF;
        if (w_dec_en) begin
            w_dec_y_n[dec_a] = 1'b0;
        end
    end

    assign w_bus_en = ~bus_en_n;

    // Ascending scan so the highest-indexed enabled source overrides the rest.
    always_comb begin
        w_bus_y = 32'h0;
        for (int k = 0; k < N; k++) begin
            if (w_bus_en[k]) begin
                w_bus_y = bus_d[32*k +: 32];
            end
        end
    end

    assign w_bus_valid    = |w_bus_en;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign w_bus_conflict = |(w_bus_en & (w_bus_en - c_one));

    assign w_mux_y = mux_s ? mux_b : mux_a;

    generate
        if (REG_OUT) begin : g_reg
            logic [7:0]  r_dec_y_n;
            logic [31:0] r_bus_y;
            logic        r_bus_valid;
            logic        r_bus_conflict;
            logic [31:0] r_mux_y;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_dec_y_n      <= 8'hFF;
                    r_bus_y        <= 32'h0;
                    r_bus_valid    <= 1'b0;
                    r_bus_conflict <= 1'b0;
                    r_mux_y        <= 32'h0;
                end else begin
                    r_dec_y_n      <= w_dec_y_n;
                    r_bus_y        <= w_bus_y;
                    r_bus_valid    <= w_bus_valid;
                    r_bus_conflict <= w_bus_conflict;
                    r_mux_y        <= w_mux_y;
                end
            end

            assign dec_y_n      = r_dec_y_n;
            assign bus_y        = r_bus_y;
            assign bus_valid    = r_bus_valid;
            assign bus_conflict = r_bus_conflict;
            assign mux_y        = r_mux_y;
        end else begin : g_comb
            assign dec_y_n      = rst ? 8'hFF  : w_dec_y_n;
            assign bus_y        = rst ? 32'h0  : w_bus_y;
            assign bus_valid    = rst ? 1'b0   : w_bus_valid;
            assign bus_conflict = rst ? 1'b0   : w_bus_conflict;
            assign mux_y        = rst ? 32'h0  : w_mux_y;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_dec138_bus32_mux32.sv
`default_nettype none
// ============================================================================
// Module  : tb_dec138_bus32_mux32
// Brief   : Randomised + directed bench against a behavioural reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dec138_bus32_mux32;

    localparam int c_n = 3;

    logic            clk;
    logic            rst;
    logic [2:0]      dec_a;
    logic            dec_g1;
    logic            dec_g2a_n;
    logic            dec_g2b_n;
    logic [7:0]      dec_y_n;
    logic [c_n-1:0]  bus_en_n;
    logic [32*c_n-1:0] bus_d;
    logic [31:0]     bus_y;
    logic            bus_valid;
    logic            bus_conflict;
    logic [31:0]     mux_a;
    logic [31:0]     mux_b;
    logic            mux_s;
    logic [31:0]     mux_y;

    int n_checks = 0;
    int n_errors = 0;

    dec138_bus32_mux32 #(.N(c_n), .REG_OUT(1'b1)) dut (
        .clk(clk), .rst(rst),
        .dec_a(dec_a), .dec_g1(dec_g1), .dec_g2a_n(dec_g2a_n), .dec_g2b_n(dec_g2b_n),
        .dec_y_n(dec_y_n),
        .bus_en_n(bus_en_n), .bus_d(bus_d),
        .bus_y(bus_y), .bus_valid(bus_valid), .bus_conflict(bus_conflict),
        .mux_a(mux_a), .mux_b(mux_b), .mux_s(mux_s), .mux_y(mux_y)
    );

    // Two combinational instances wired as a decoder cascade.
    logic [2:0]  ca_a;
    logic [7:0]  ca_y_n;
    logic [7:0]  cb_y_n;
    logic [31:0] ca_bus_y, cb_bus_y, ca_mux_y, cb_mux_y;
    logic        ca_bv, ca_bc, cb_bv, cb_bc;

    dec138_bus32_mux32 #(.N(1), .REG_OUT(1'b0)) casc_a (
        .clk(clk), .rst(rst),
        .dec_a(ca_a), .dec_g1(1'b1), .dec_g2a_n(1'b0), .dec_g2b_n(1'b0),
        .dec_y_n(ca_y_n),
        .bus_en_n(1'b1), .bus_d(32'h0),
        .bus_y(ca_bus_y), .bus_valid(ca_bv), .bus_conflict(ca_bc),
        .mux_a(32'h0), .mux_b(32'h0), .mux_s(1'b0), .mux_y(ca_mux_y)
    );

    dec138_bus32_mux32 #(.N(1), .REG_OUT(1'b0)) casc_b (
        .clk(clk), .rst(rst),
        .dec_a(3'd2), .dec_g1(1'b1), .dec_g2a_n(1'b0), .dec_g2b_n(ca_y_n[0]),
        .dec_y_n(cb_y_n),
        .bus_en_n(1'b1), .bus_d(32'h0),
        .bus_y(cb_bus_y), .bus_valid(cb_bv), .bus_conflict(cb_bc),
        .mux_a(32'h0), .mux_b(32'h0), .mux_s(1'b0), .mux_y(cb_mux_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Reference model: behaviour stated in terms of the unit rules.
    function automatic logic [7:0] m_dec(input logic [2:0] a, input logic g1,
                                         input logic g2a_n, input logic g2b_n);
        if (g1 && !g2a_n && !g2b_n) return 8'hFF ^ (8'(1) << a);
        return 8'hFF;
    endfunction

    task automatic m_bus(input logic [c_n-1:0] en_n, input logic [32*c_n-1:0] d,
                         output logic [31:0] y, output logic v, output logic c);
        int cnt = 0;
        int top = -1;
        for (int k = 0; k < c_n; k++) begin
            if (en_n[k] == 1'b0) begin
                cnt++;
                top = k;
            end
        end
        y = (top < 0) ? 32'h0 : d[32*top +: 32];
        v = (cnt >= 1);
        c = (cnt >= 2);
    endtask

    task automatic check_all(input string tag);
        logic [31:0] ey;
        logic ev, ec;
        m_bus(bus_en_n, bus_d, ey, ev, ec);
        chk({tag, ".dec"}, {24'h0, dec_y_n}, {24'h0, m_dec(dec_a, dec_g1, dec_g2a_n, dec_g2b_n)});
        chk({tag, ".bus"}, bus_y, ey);
        chk({tag, ".valid"}, {31'h0, bus_valid}, {31'h0, ev});
        chk({tag, ".conflict"}, {31'h0, bus_conflict}, {31'h0, ec});
        chk({tag, ".mux"}, mux_y, mux_s ? mux_b : mux_a);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ".dec"}, {24'h0, dec_y_n}, 32'h0000_00FF);
        chk({tag, ".bus"}, bus_y, 32'h0);
        chk({tag, ".valid"}, {31'h0, bus_valid}, 32'h0);
        chk({tag, ".conflict"}, {31'h0, bus_conflict}, 32'h0);
        chk({tag, ".mux"}, mux_y, 32'h0);
    endtask

    // Inputs are held across the edge; outputs compared #1 after it.
    task automatic step(input string tag);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        rst = 1'b1;
        dec_a = 3'd3; dec_g1 = 1'b1; dec_g2a_n = 1'b0; dec_g2b_n = 1'b0;
        bus_en_n = 3'b000; bus_d = {32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
        mux_a = 32'hA5A5_A5A5; mux_b = 32'h5A5A_5A5A; mux_s = 1'b1;
        ca_a = 3'd0;
        #3;
        check_reset("reset_init");
        @(posedge clk); #1;
        check_reset("reset_hold");
        @(negedge clk);
        rst = 1'b0;
        step("first_after_reset");

        for (int i = 0; i < 8; i++) begin
            dec_a = 3'(i); dec_g1 = 1'b1; dec_g2a_n = 1'b0; dec_g2b_n = 1'b0;
            step("dec_sweep");
        end
        dec_a = 3'd3;
        dec_g1 = 1'b0; step("dec_g1_off");
        dec_g1 = 1'b1; dec_g2a_n = 1'b1; step("dec_g2a_off");
        dec_g2a_n = 1'b0; dec_g2b_n = 1'b1; step("dec_g2b_off");
        dec_g2b_n = 1'b0;

        bus_d = {32'hFFFF_F000, 32'h0000_0ABC, 32'h0000_0123};
        bus_en_n = 3'b101; step("bus_one");
        chk("bus_one_lit", bus_y, 32'h0000_0ABC);
        bus_en_n = 3'b111; step("bus_none");
        chk("bus_none_lit", bus_y, 32'h0);
        bus_en_n = 3'b010; step("bus_conflict");
        chk("bus_conflict_lit", bus_y, 32'hFFFF_F000);

        mux_a = 32'h0000_1000; mux_b = 32'h0; mux_s = 1'b0; step("mux_s0");
        chk("mux_s0_lit", mux_y, 32'h0000_1000);
        mux_s = 1'b1; step("mux_s1");
        mux_a = 32'h4; mux_b = 32'hDEAD_BEEF; step("mux_s1b");
        chk("mux_s1b_lit", mux_y, 32'hDEAD_BEEF);

        // Latency: new select only becomes visible on the following edge.
        dec_a = 3'd2; step("lat_pre");
        dec_a = 3'd5;
        @(negedge clk);
        chk("lat_hold", {24'h0, dec_y_n}, 32'h0000_00FB);
        @(posedge clk); #1;
        chk("lat_new", {24'h0, dec_y_n}, 32'h0000_00DF);

        // Asynchronous reset mid-stream, between edges.
        bus_en_n = 3'b011;
        step("pre_async");
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        check_reset("async_rst");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_reset("rst_held");
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset("rst_released_no_edge");
        step("post_rst");

        // Cascade through combinational instances.
        ca_a = 3'd0; #1;
        chk("casc_a0", {24'h0, cb_y_n}, 32'h0000_00FB);
        ca_a = 3'd1; #1;
        chk("casc_a1", {24'h0, cb_y_n}, 32'h0000_00FF);
        ca_a = 3'd0; #1;
        rst = 1'b1; #1;
        chk("casc_comb_rst", {24'h0, cb_y_n}, 32'h0000_00FF);
        @(negedge clk);
        rst = 1'b0;
        step("post_casc_rst");

        for (int i = 0; i < 300; i++) begin
            dec_a     = 3'($urandom_range(0, 7));
            dec_g1    = ($urandom_range(0, 3) != 0);
            dec_g2a_n = ($urandom_range(0, 3) == 0);
            dec_g2b_n = ($urandom_range(0, 3) == 0);
            bus_en_n  = 3'($urandom_range(0, 7));
            bus_d     = {$urandom(), $urandom(), $urandom()};
            mux_a     = $urandom();
            mux_b     = $urandom();
            mux_s     = 1'($urandom_range(0, 1));
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
